snes_clk_meter: RTL and testbench
=================================

Name: snes_clk_meter

Overview:
- Frequency counter that measures the SNES system clock (sysclk), which is asynchronous to the FPGA main clock.
- Counts sysclk rising edges over a fixed gate window of GATE_CYCLES main-clock cycles, then publishes the count.
- With GATE_CYCLES equal to the main clock frequency in Hz, the result is sysclk frequency in Hz.
- Sits beside the MCU command decoder, which reads the 32-bit result over SPI as four bytes, MSB first.

Parameters:
- GATE_CYCLES, 86000000: gate window length in clk cycles. Range 2..2^32-1.

Ports:
- clk  input  1  main FPGA clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sysclk  input  1  SNES system clock, asynchronous; frequency must be < clk/2.
- snes_sysclk_freq  output  32  sysclk rising-edge count from the last completed gate window.
- freq_valid  output  1  0 after reset; set to 1 at the first window completion and held at 1.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, all of the following are 0:
  - synchronizer flops s1, s2, s3;
  - gate counter;
  - edge counter;
  - snes_sysclk_freq;
  - freq_valid.
- Synchronizer: each clk, s1<=sysclk, s2<=s1, s3<=s2.
- Edge detect: edge = s2 & ~s3 (combinational). One pulse per sysclk rising edge. Edge reaches the detector 2 clk after it is sampled into s1.
- Gate counter: counts 0..GATE_CYCLES-1, incrementing every clk.
- At terminal count (gate counter = GATE_CYCLES-1), on the same edge:
  - gate counter <= 0;
  - snes_sysclk_freq <= edge counter + edge (edge counted in this last cycle is included);
  - edge counter <= 0 (an edge in this cycle is not double-counted into the next window);
  - freq_valid <= 1.
- Other cycles: if edge, edge counter <= edge counter + 1, saturating at 32'hFFFFFFFF (no wrap).
- Window length is exactly GATE_CYCLES clk cycles. The first window starts at the first clk edge after rst_n deasserts.
- Output update and latency:
  - snes_sysclk_freq changes only at terminal count, otherwise holds; glitch-free, fully registered.
  - Result is valid from the clk edge ending each window until the next window ends.
- Stopped sysclk (constant 0 or 1) gives a result of 0 for every full window after the last edge.
- Reset mid-window: counters and output clear immediately (async). The partial count is discarded and freq_valid returns to 0.
- Metastability: only s1 may go metastable; no logic other than s2 reads s1.

Test Plan:
- Reset check: hold rst_n=0 and toggle sysclk -> snes_sysclk_freq=0, freq_valid=0, no change until first terminal count.
- Nominal ratio: GATE_CYCLES=100, sysclk toggles every 5 clk -> freq_valid rises at clk cycle 100 after reset release; first result in {9,10,11}; second and later results exactly 10.
- Stopped clock: GATE_CYCLES=100, sysclk held 0 after first window -> second window result 0; freq_valid stays 1.
- Boundary edge: place a detected edge exactly in the terminal-count cycle -> counted once in that window's result and not in the next window.
- Mid-window reset: GATE_CYCLES=100, assert rst_n=0 at cycle 50 of the second window -> output 0 and freq_valid 0 immediately. After release, the next result appears 100 cycles later with value 10 ±1.
- Saturation: force the edge counter to 32'hFFFFFFFE, then apply 3 edges in the window -> result 32'hFFFFFFFF.

Source files
------------

// File: rtl/snes_clk_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : snes_clk_meter
// Brief    : Gated frequency counter for the asynchronous SNES sysclk.
// Revision : 1.0 - initial release
// ============================================================================
module snes_clk_meter #(
    parameter int unsigned GATE_CYCLES = 86000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sysclk,
    output logic [31:0] snes_sysclk_freq,
    output logic        freq_valid
);

    localparam logic [31:0] C_GATE_LAST = 32'(GATE_CYCLES - 1);

    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic [31:0] r_gate_cnt;
    logic [31:0] r_edge_cnt;
    logic [31:0] r_freq;
    logic        r_valid;

    logic        w_edge;
    logic        w_terminal;
    logic [31:0] w_edge_next;

    // r_s1 is the only flop allowed to go metastable; only r_s2 reads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sysclk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge     = r_s2 & ~r_s3;
    assign w_terminal = (r_gate_cnt == C_GATE_LAST);

    // Saturating count including the current cycle's edge.
    always_comb begin
        w_edge_next = r_edge_cnt;
        if (w_edge && (r_edge_cnt != 32'hFFFF_FFFF)) begin
            w_edge_next = r_edge_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt <= 32'd0;
        end else if (w_terminal) begin
            r_gate_cnt <= 32'd0;
        end else begin
            r_gate_cnt <= r_gate_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= 32'd0;
        end else if (w_terminal) begin
            r_edge_cnt <= 32'd0;
        end else if (w_edge) begin
            r_edge_cnt <= w_edge_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_freq  <= 32'd0;
            r_valid <= 1'b0;
        end else if (w_terminal) begin
            r_freq  <= w_edge_next;
            r_valid <= 1'b1;
        end
    end

    assign snes_sysclk_freq = r_freq;
    assign freq_valid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_snes_clk_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_snes_clk_meter
// Brief    : Self-checking bench for snes_clk_meter with a 100-cycle gate.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snes_clk_meter;

    localparam int unsigned GATE = 100;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        sysclk = 1'b0;
    logic [31:0] freq;
    logic        valid;

    snes_clk_meter #(.GATE_CYCLES(GATE)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sysclk           (sysclk),
        .snes_sysclk_freq (freq),
        .freq_valid       (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned win;
        logic [31:0] value;
        int unsigned tol;
    } exp_t;

    typedef struct {
        string       name;
        int unsigned half;
        logic        level;
        logic [31:0] expect_v;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        e;
    vec_t        vecs[7];
    int          tests = 0;
    int          fails = 0;
    int unsigned bcnt;
    int unsigned gen_half  = 0;
    logic        gen_level = 1'b0;
    int unsigned gen_cnt   = 0;

    // Clock edges since reset release; a window ends whenever bcnt hits a multiple of GATE.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt <= 0;
        else        bcnt <= bcnt + 1;
    end

    // sysclk stimulus: toggles every gen_half clk cycles, or holds gen_level when gen_half is 0.
    always @(negedge clk) begin
        if (gen_half == 0) begin
            sysclk = gen_level;
            gen_cnt = 0;
        end else begin
            gen_cnt = gen_cnt + 1;
            if (gen_cnt >= gen_half) begin
                gen_cnt = 0;
                sysclk = ~sysclk;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input logic [31:0] act,
                             input logic [31:0] req, input int unsigned tol);
        logic [31:0] diff;
        diff = (act > req) ? act - req : req - act;
        tests++;
        if ($isunknown(act) || diff > tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, req, tol);
        end
    endtask

    task automatic push(input string name, input int unsigned off,
                        input logic [31:0] value, input int unsigned tol);
        exp_t x;
        x.name  = name;
        x.win   = bcnt / GATE + off;
        x.value = value;
        x.tol   = tol;
        exp_q.push_back(x);
    endtask

    task automatic wait_mod(input int unsigned m);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((bcnt % GATE) != m && n < 3 * GATE);
        if ((bcnt % GATE) != m) begin
            tests++;
            fails++;
            $display("FAIL wait_mod: phase %0d never reached, at %0d", m, bcnt % GATE);
        end
    endtask

    // Scoreboard: pop results due at each window end.
    always @(negedge clk) begin
        if (rst_n && bcnt != 0 && (bcnt % GATE) == 0) begin
            while (exp_q.size() > 0 && exp_q[0].win <= bcnt / GATE) begin
                e = exp_q.pop_front();
                if (e.win == bcnt / GATE) begin
                    check_tol(e.name, freq, e.value, e.tol);
                    check({e.name, "_valid"}, {31'd0, valid}, 32'd1);
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL %s: window %0d result never compared", e.name, e.win);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"half5",      5,  1'b0, 32'd10};
        vecs[1] = '{"half2",      2,  1'b0, 32'd25};
        vecs[2] = '{"half10",     10, 1'b0, 32'd5};
        vecs[3] = '{"half25",     25, 1'b0, 32'd2};
        vecs[4] = '{"half50",     50, 1'b0, 32'd1};
        vecs[5] = '{"stopped_lo", 0,  1'b0, 32'd0};
        vecs[6] = '{"stopped_hi", 0,  1'b1, 32'd0};

        // Reset held while sysclk toggles
        gen_half = 3;
        repeat (20) @(posedge clk);
        #1;
        check("reset_freq", freq, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);

        gen_half = 5;
        @(negedge clk);
        rst_n = 1'b1;
        push("first_window", 1, 32'd10, 1);
        push("second_window", 2, 32'd10, 0);
        wait_mod(50);
        check("mid_first_freq", freq, 32'd0);
        check("mid_first_valid", {31'd0, valid}, 32'd0);
        wait_mod(99);
        check("pre_tc_freq", freq, 32'd0);
        check("pre_tc_valid", {31'd0, valid}, 32'd0);
        wait_mod(0);
        check("first_tc_valid", {31'd0, valid}, 32'd1);
        wait_mod(0);

        // Steady-state ratios: one transitional window, then an exact result
        for (int i = 0; i < 7; i++) begin
            gen_half  = vecs[i].half;
            gen_level = vecs[i].level;
            push(vecs[i].name, 2, vecs[i].expect_v, 0);
            wait_mod(0);
            wait_mod(0);
        end

        // Edge detected in the terminal-count cycle belongs to the ending window
        gen_half  = 0;
        gen_level = 1'b0;
        wait_mod(0);
        wait_mod(97);
        gen_level = 1'b1;
        push("edge_in_tc", 1, 32'd1, 0);
        push("edge_in_tc_next", 2, 32'd0, 0);
        wait_mod(0);
        wait_mod(50);
        gen_level = 1'b0;
        wait_mod(0);
        // One cycle later it lands in the next window
        wait_mod(98);
        gen_level = 1'b1;
        push("edge_after_tc", 1, 32'd0, 0);
        push("edge_after_tc_next", 2, 32'd1, 0);
        wait_mod(0);
        wait_mod(0);

        // Mid-window reset
        gen_half = 5;
        wait_mod(0);
        wait_mod(0);
        wait_mod(50);
        check("queue_drained_pre_reset", exp_q.size(), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midreset_freq", freq, 32'd0);
        check("midreset_valid", {31'd0, valid}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push("after_reset", 1, 32'd10, 1);
        push("after_reset_next", 2, 32'd10, 0);
        wait_mod(99);
        check("after_reset_pre_tc_valid", {31'd0, valid}, 32'd0);
        wait_mod(0);
        check("after_reset_tc_valid", {31'd0, valid}, 32'd1);
        wait_mod(0);

        // Saturation from a preloaded edge count
        gen_half  = 0;
        gen_level = 1'b0;
        wait_mod(0);
        wait_mod(10);
        force dut.r_edge_cnt = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.r_edge_cnt;
        push("saturate", 1, 32'hFFFF_FFFF, 0);
        push("after_saturate", 2, 32'd0, 0);
        repeat (3) begin
            gen_level = 1'b1;
            repeat (4) @(posedge clk);
            gen_level = 1'b0;
            repeat (4) @(posedge clk);
        end
        wait_mod(0);
        wait_mod(0);
        @(negedge clk);
        #1;
        check("queue_drained_end", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
